// File: rtl/serial_mult_ctrl_pkg.sv
// serial_mult_ctrl_pkg: state encoding and counter sizing shared by the serial multiplier
package serial_mult_ctrl_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/serial_mult_ctrl_fulladder.sv
// serial_mult_ctrl_fulladder: single-bit full adder slice
module serial_mult_ctrl_fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_mult_ctrl.sv
// serial_mult_ctrl: bit-serial shift-add unsigned multiplier built on one full adder slice
module serial_mult_ctrl
    import serial_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = clog2(WIDTH);
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic               carry;
    logic [CW-1:0]      i_cnt, j_cnt;
    logic               sum, cout;
    logic               last_i, last_j;
    assign last_i = i_cnt == CW'(WIDTH - 1);
    assign last_j = j_cnt == CW'(WIDTH - 1);
    assign busy   = state == ADD || state == SHIFT;
    assign done   = state == DONE;
    // P_hi rotates right through the slice, so bit 0 is always the next addend bit
    serial_mult_ctrl_fulladder u_fa (
        .x    (p[WIDTH]),
        .y    (mcand[j_cnt] & p[0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ADD : IDLE;
            ADD:     state_nxt = last_j ? SHIFT : ADD;
            SHIFT:   state_nxt = last_i ? DONE : ADD;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            p       <= '0;
            carry   <= 1'b0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    mcand <= a;
                    p     <= {{WIDTH{1'b0}}, b};
                    carry <= 1'b0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                end
                ADD: begin
                    p[2*WIDTH-1:WIDTH] <= {sum, p[2*WIDTH-1:WIDTH+1]};
                    carry              <= cout;
                    j_cnt              <= last_j ? '0 : j_cnt + 1'b1;
                end
                SHIFT: begin
                    p     <= {carry, p[2*WIDTH-1:1]};
                    carry <= 1'b0;
                    i_cnt <= last_i ? '0 : i_cnt + 1'b1;
                    // capture the final shifted value so product is valid while done is high
                    if (last_i) product <= {carry, p[2*WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end
endmodule
